weekday_engine: RTL and testbench

//  Computes the weekday, day-of-year and leap flag for any date within a parametrised year window.

---
 rtl/weekday_engine_if.sv | 28 ++
 rtl/weekday_engine.sv | 219 +++++++++++++++++++++
 tb/tb_weekday_engine.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/weekday_engine_if.sv
// Date request and calendar result bundle between the clock/calendar counters and weekday_engine.
interface weekday_engine_if #(
  parameter int YEAR_W = 12
);
  logic              sync;
  logic [2:0]        weekday_in;
  logic [3:0]        day10;
  logic [3:0]        day1;
  logic [3:0]        month10;
  logic [3:0]        month1;
  logic [YEAR_W-1:0] year;
  logic [2:0]        weekday;
  logic [8:0]        day_of_year;
  logic              leap;
  logic              busy;
  logic              valid;
  logic              date_err;

  modport master (
    output sync, weekday_in, day10, day1, month10, month1, year,
    input  weekday, day_of_year, leap, busy, valid, date_err
  );

  modport slave (
    input  sync, weekday_in, day10, day1, month10, month1, year,
    output weekday, day_of_year, leap, busy, valid, date_err
  );
endinterface

// File: rtl/weekday_engine.sv
// Weekday / day-of-year / leap from an absolute date by iterative day counting; latency Y+M+5 cycles.
// No backpressure: inputs are ignored while busy and a pending change is picked up on return to IDLE.
module weekday_engine #(
  parameter int YEAR_W       = 12,
  parameter int BASE_YEAR    = 2024,
  parameter int BASE_WEEKDAY = 1,
  parameter int YEAR_SPAN    = 128
) (
  input  logic            clk,
  input  logic            reset,
  weekday_engine_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CHECK, YEARS, MONTHS, DAYS, DONE} state_t;

  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    int yi;
    yi = int'(y);
    return ((yi % 4 == 0) && (yi % 100 != 0)) || (yi % 400 == 0);
  endfunction

  function automatic logic [4:0] dim(input logic [7:0] mon, input logic lp);
    if (mon == 8'd2)
      return lp ? 5'd29 : 5'd28;
    else if (mon == 8'd4 || mon == 8'd6 || mon == 8'd9 || mon == 8'd11)
      return 5'd30;
    else
      return 5'd31;
  endfunction

  function automatic logic [2:0] mod7(input logic [4:0] v);
    logic [4:0] r;
    r = v;
    for (int i = 0; i < 4; i++)
      if (r >= 5'd7) r = r - 5'd7;
    return r[2:0];
  endfunction

  function automatic logic [2:0] add7(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 4'd7) s = s - 4'd7;
    return s[2:0];
  endfunction

  function automatic logic [2:0] sub7(input logic [2:0] a, input logic [2:0] b);
    return (a >= b) ? (a - b) : (a + 3'd7 - b);
  endfunction

  state_t            state, state_nx;
  logic [3:0]        d10_q, d1_q, m10_q, m1_q, d10_nx, d1_nx, m10_nx, m1_nx;
  logic [YEAR_W-1:0] yr_q, yr_nx, y_q, y_nx;
  logic [2:0]        wd_lat_q, wd_lat_nx, acc_q, acc_nx, corr_q, corr_nx;
  logic [3:0]        m_q, m_nx;
  logic [8:0]        doy_q, doy_nx;
  logic              sync_pend_q, sync_pend_nx;
  logic [2:0]        weekday_q, weekday_nx;
  logic [8:0]        day_of_year_q, day_of_year_nx;
  logic              leap_q, leap_nx, busy_q, busy_nx, valid_q, valid_nx, err_q, err_nx;

  logic [7:0] mon_bin, day_bin;
  logic       yr_leap, date_bad;

  assign mon_bin = {4'd0, m10_q} * 8'd10 + {4'd0, m1_q};
  assign day_bin = {4'd0, d10_q} * 8'd10 + {4'd0, d1_q};
  assign yr_leap = is_leap(yr_q);

  // Out-of-range months still produce some dim(); the month check rejects them anyway.
  assign date_bad = (d10_q > 4'd9) || (d1_q > 4'd9) || (m10_q > 4'd9) || (m1_q > 4'd9)
                 || (mon_bin == 8'd0) || (mon_bin > 8'd12)
                 || (day_bin == 8'd0) || (day_bin > {3'd0, dim(mon_bin, yr_leap)})
                 || (int'(yr_q) < BASE_YEAR) || (int'(yr_q) > BASE_YEAR + YEAR_SPAN - 1)
                 || (sync_pend_q && (wd_lat_q > 3'd6));

  always_comb begin
    state_nx       = state;
    d10_nx         = d10_q;
    d1_nx          = d1_q;
    m10_nx         = m10_q;
    m1_nx          = m1_q;
    yr_nx          = yr_q;
    y_nx           = y_q;
    wd_lat_nx      = wd_lat_q;
    acc_nx         = acc_q;
    corr_nx        = corr_q;
    m_nx           = m_q;
    doy_nx         = doy_q;
    sync_pend_nx   = sync_pend_q;
    weekday_nx     = weekday_q;
    day_of_year_nx = day_of_year_q;
    leap_nx        = leap_q;
    busy_nx        = busy_q;
    valid_nx       = valid_q;
    err_nx         = err_q;
    case (state)
      IDLE: begin
        if (bus.sync || (bus.day10 != d10_q) || (bus.day1 != d1_q) || (bus.month10 != m10_q)
            || (bus.month1 != m1_q) || (bus.year != yr_q)) begin
          d10_nx   = bus.day10;
          d1_nx    = bus.day1;
          m10_nx   = bus.month10;
          m1_nx    = bus.month1;
          yr_nx    = bus.year;
          busy_nx  = 1'b1;
          valid_nx = 1'b0;
          state_nx = CHECK;
          if (bus.sync) begin
            wd_lat_nx    = bus.weekday_in;
            sync_pend_nx = 1'b1;
          end
        end
      end
      CHECK: begin
        if (date_bad) begin
          err_nx       = 1'b1;
          busy_nx      = 1'b0;
          valid_nx     = 1'b1;
          sync_pend_nx = 1'b0;
          state_nx     = IDLE;
        end else begin
          err_nx   = 1'b0;
          acc_nx   = 3'(BASE_WEEKDAY);
          y_nx     = YEAR_W'(BASE_YEAR);
          m_nx     = 4'd1;
          doy_nx   = 9'd0;
          state_nx = YEARS;
        end
      end
      YEARS: begin
        if (y_q == yr_q) begin
          state_nx = MONTHS;
        end else begin
          // 365 % 7 == 1, 366 % 7 == 2
          acc_nx = add7(acc_q, is_leap(y_q) ? 3'd2 : 3'd1);
          y_nx   = y_q + 1'b1;
        end
      end
      MONTHS: begin
        if ({4'd0, m_q} == mon_bin) begin
          state_nx = DAYS;
        end else begin
          acc_nx = add7(acc_q, mod7(dim({4'd0, m_q}, yr_leap)));
          doy_nx = doy_q + {4'd0, dim({4'd0, m_q}, yr_leap)};
          m_nx   = m_q + 4'd1;
        end
      end
      DAYS: begin
        acc_nx   = add7(acc_q, mod7(day_bin[4:0] - 5'd1));
        doy_nx   = doy_q + {1'b0, day_bin};
        state_nx = DONE;
      end
      DONE: begin
        if (sync_pend_q) begin
          corr_nx      = sub7(wd_lat_q, acc_q);
          weekday_nx   = wd_lat_q;
          sync_pend_nx = 1'b0;
        end else begin
          weekday_nx = add7(acc_q, corr_q);
        end
        day_of_year_nx = doy_q;
        leap_nx        = yr_leap;
        busy_nx        = 1'b0;
        valid_nx       = 1'b1;
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      d10_q         <= 4'd0;
      d1_q          <= 4'd1;
      m10_q         <= 4'd0;
      m1_q          <= 4'd1;
      yr_q          <= YEAR_W'(BASE_YEAR);
      y_q           <= YEAR_W'(BASE_YEAR);
      wd_lat_q      <= 3'd0;
      acc_q         <= 3'(BASE_WEEKDAY);
      corr_q        <= 3'd0;
      m_q           <= 4'd1;
      doy_q         <= 9'd0;
      sync_pend_q   <= 1'b0;
      weekday_q     <= 3'(BASE_WEEKDAY);
      day_of_year_q <= 9'd1;
      leap_q        <= is_leap(YEAR_W'(BASE_YEAR));
      busy_q        <= 1'b0;
      valid_q       <= 1'b1;
      err_q         <= 1'b0;
    end else begin
      state         <= state_nx;
      d10_q         <= d10_nx;
      d1_q          <= d1_nx;
      m10_q         <= m10_nx;
      m1_q          <= m1_nx;
      yr_q          <= yr_nx;
      y_q           <= y_nx;
      wd_lat_q      <= wd_lat_nx;
      acc_q         <= acc_nx;
      corr_q        <= corr_nx;
      m_q           <= m_nx;
      doy_q         <= doy_nx;
      sync_pend_q   <= sync_pend_nx;
      weekday_q     <= weekday_nx;
      day_of_year_q <= day_of_year_nx;
      leap_q        <= leap_nx;
      busy_q        <= busy_nx;
      valid_q       <= valid_nx;
      err_q         <= err_nx;
    end
  end

  assign bus.weekday     = weekday_q;
  assign bus.day_of_year = day_of_year_q;
  assign bus.leap        = leap_q;
  assign bus.busy        = busy_q;
  assign bus.valid       = valid_q;
  assign bus.date_err    = err_q;
endmodule

// File: tb/tb_weekday_engine.sv
// Directed bench for weekday_engine: hand-computed weekday/doy/leap/latency per date.
module tb_weekday_engine;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc;

  weekday_engine_if #(.YEAR_W(12)) bus ();

  weekday_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_date(input int y, input int m, input int d);
    bus.year    = 12'(y);
    bus.month10 = 4'(m / 10);
    bus.month1  = 4'(m % 10);
    bus.day10   = 4'(d / 10);
    bus.day1    = 4'(d % 10);
  endtask

  // Counts negedges until busy drops; equals the latency when inputs change just after a negedge.
  task automatic run_calc(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 1000);
  endtask

  task automatic chk_out(input string tag, input int wd, input int doy, input int lp);
    chk({tag, ".weekday"}, 32'(bus.weekday), 32'(wd));
    chk({tag, ".doy"},     32'(bus.day_of_year), 32'(doy));
    chk({tag, ".leap"},    32'(bus.leap), 32'(lp));
    chk({tag, ".valid"},   32'(bus.valid), 32'd1);
  endtask

  initial begin
    reset          = 1'b0;
    bus.sync       = 1'b0;
    bus.weekday_in = 3'd0;
    set_date(2024, 1, 1);

    // T1: reset and idle on the epoch date
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1.busy", 32'(bus.busy), 32'd0);
    chk("t1.err",  32'(bus.date_err), 32'd0);
    chk_out("t1", 1, 1, 1);

    // T2
    set_date(2024, 3, 1);
    run_calc(cyc);
    chk("t2.lat", 32'(cyc), 32'd8);
    chk_out("t2", 5, 61, 1);

    // T3: crosses the non-leap century year
    set_date(2100, 3, 1);
    run_calc(cyc);
    chk("t3.lat", 32'(cyc), 32'd84);
    chk_out("t3", 1, 60, 0);

    // Last day of the last valid year
    set_date(2151, 12, 31);
    run_calc(cyc);
    chk("top.lat", 32'(cyc), 32'd144);
    chk_out("top", 5, 365, 0);

    // T4: sync forces Sunday, computed value would be Wednesday -> corr = 4
    set_date(2025, 1, 1);
    bus.sync       = 1'b1;
    bus.weekday_in = 3'd0;
    run_calc(cyc);
    bus.sync = 1'b0;
    chk("t4.lat", 32'(cyc), 32'd7);
    chk_out("t4", 0, 1, 0);
    set_date(2025, 1, 2);
    run_calc(cyc);
    chk("t4b.lat", 32'(cyc), 32'd7);
    chk_out("t4b", 1, 2, 0);

    // T5: invalid date below the window
    set_date(2023, 2, 30);
    @(negedge clk);
    chk("t5.busy1", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("t5.err", 32'(bus.date_err), 32'd1);
    chk("t5.busy2", 32'(bus.busy), 32'd0);
    chk_out("t5", 1, 2, 0);
    set_date(2025, 1, 3);
    run_calc(cyc);
    chk("t5b.err", 32'(bus.date_err), 32'd0);
    chk_out("t5b", 2, 3, 0);
    set_date(2152, 1, 1);
    repeat (2) @(negedge clk);
    chk("t5c.err", 32'(bus.date_err), 32'd1);
    chk("t5c.wd",  32'(bus.weekday), 32'd2);

    // Sync with an out-of-range weekday is rejected
    set_date(2025, 1, 3);
    bus.sync       = 1'b1;
    bus.weekday_in = 3'd7;
    repeat (2) @(negedge clk);
    bus.sync = 1'b0;
    chk("wdbad.err", 32'(bus.date_err), 32'd1);
    chk("wdbad.wd",  32'(bus.weekday), 32'd2);
    @(negedge clk);
    chk("wdbad.idle", 32'(bus.busy), 32'd0);

    // T6: reset during YEARS of the 2100 calculation
    set_date(2100, 3, 1);
    repeat (10) @(negedge clk);
    chk("t6.busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("t6.busy0", 32'(bus.busy), 32'd0);
    chk("t6.err",   32'(bus.date_err), 32'd0);
    chk_out("t6", 1, 1, 1);
    set_date(2024, 1, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6.idle", 32'(bus.busy), 32'd0);

    // Date change mid-calculation; corr was cleared by reset
    set_date(2024, 3, 1);
    repeat (3) @(negedge clk);
    set_date(2024, 12, 31);
    cyc = 3;
    while (bus.busy && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid1.lat", 32'(cyc), 32'd8);
    chk_out("mid1", 5, 61, 1);
    run_calc(cyc);
    chk("mid2.lat", 32'(cyc), 32'd17);
    chk_out("mid2", 2, 366, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
